// File: rtl/prog_loader.sv
// Serial program loader: parses a framed UART byte stream into 18-bit instructions,
// writes them sequentially into the program RAM and holds the MCU in reset meanwhile.
module prog_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 18,
    parameter logic [7:0]  SYNC        = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              PROG_CLK,
    input  logic              PROG_RST_N,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    input  logic              LOAD_EN,
    output logic              PROG_WE,
    output logic [ADDR_W-1:0] PROG_WADDR,
    output logic [DATA_W-1:0] PROG_WDATA,
    output logic              MCU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR,
    output logic [1:0]        ERR_CODE
);

    localparam int unsigned CntW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StLenHi = 4'd1;
    localparam logic [3:0] StLenLo = 4'd2;
    localparam logic [3:0] StB0    = 4'd3;
    localparam logic [3:0] StB1    = 4'd4;
    localparam logic [3:0] StB2    = 4'd5;
    localparam logic [3:0] StCk    = 4'd6;
    localparam logic [3:0] StDone  = 4'd7;
    localparam logic [3:0] StErr   = 4'd8;

    localparam logic [1:0] ErrLen = 2'b01;
    localparam logic [1:0] ErrCk  = 2'b10;
    localparam logic [1:0] ErrTmo = 2'b11;

    logic [3:0]        state_q, state_d;
    logic [1:0]        len_hi_q, len_hi_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [1:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        xor_q, xor_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              in_frame;

    assign in_frame = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        xor_d    = xor_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        code_d   = code_q;

        // Inter-byte silence counter only runs while a frame is in flight.
        if (RX_VALID || !in_frame) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (RX_VALID && LOAD_EN && (RX_DATA == SYNC)) begin
                    state_d = StLenHi;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                    addr_d  = '0;
                    xor_d   = 8'h00;
                end
            end
            StDone, StErr: begin
                if (!LOAD_EN) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (!LOAD_EN) begin
                    // Abort: no status change, MCU stays held.
                    state_d = StIdle;
                end else if (RX_VALID) begin
                    xor_d = xor_q ^ RX_DATA;
                    case (state_q)
                        StLenHi: begin
                            if (RX_DATA[7:2] != 6'd0) begin
                                state_d = StErr;
                                err_d   = 1'b1;
                                code_d  = ErrLen;
                            end else begin
                                len_hi_d = RX_DATA[1:0];
                                state_d  = StLenLo;
                            end
                        end
                        StLenLo: begin
                            len_d   = ADDR_W'({len_hi_q, RX_DATA});
                            state_d = StB0;
                        end
                        StB0: begin
                            b0_d    = RX_DATA[1:0];
                            state_d = StB1;
                        end
                        StB1: begin
                            b1_d    = RX_DATA;
                            state_d = StB2;
                        end
                        StB2: begin
                            wdata_d = DATA_W'({b0_q, b1_q, RX_DATA});
                            we_d    = 1'b1;
                            // addr_q already reflects this word: the previous WE was >= 2 cycles ago.
                            state_d = (addr_q == len_q) ? StCk : StB0;
                        end
                        StCk: begin
                            if (RX_DATA == xor_q) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                                hold_d  = 1'b0;
                            end else begin
                                state_d = StErr;
                                err_d   = 1'b1;
                                code_d  = ErrCk;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end else if (cnt_q == CntLast) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = ErrTmo;
                end
            end
        endcase
    end

    always_ff @(posedge PROG_CLK or negedge PROG_RST_N) begin
        if (!PROG_RST_N) begin
            state_q  <= StIdle;
            len_hi_q <= 2'b00;
            len_q    <= '0;
            b0_q     <= 2'b00;
            b1_q     <= 8'h00;
            xor_q    <= 8'h00;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            xor_q    <= xor_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign PROG_WE    = we_q;
    assign PROG_WADDR = addr_q;
    assign PROG_WDATA = wdata_q;
    assign MCU_HOLD   = hold_q;
    assign LOAD_DONE  = done_q;
    assign LOAD_ERR   = err_q;
    assign ERR_CODE   = code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a byte-position frame model predicts every output each
// cycle, and literal expectations pin the key results of each scenario.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int unsigned TMO    = 16;
    localparam logic [7:0]  SYNC_B = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        load_en  = 1'b0;
    logic        we;
    logic [9:0]  waddr;
    logic [17:0] wdata;
    logic        hold;
    logic        done;
    logic        err;
    logic [1:0]  code;

    prog_loader #(
        .ADDR_W      (10),
        .DATA_W      (18),
        .SYNC        (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .PROG_CLK   (clk),
        .PROG_RST_N (rst_n),
        .RX_DATA    (rx_data),
        .RX_VALID   (rx_valid),
        .LOAD_EN    (load_en),
        .PROG_WE    (we),
        .PROG_WADDR (waddr),
        .PROG_WDATA (wdata),
        .MCU_HOLD   (hold),
        .LOAD_DONE  (done),
        .LOAD_ERR   (err),
        .ERR_CODE   (code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame model: phase 0 idle, 1 in frame, 2 finished (waiting for LOAD_EN low).
    int          ph     = 0;
    int          pos    = 0;
    int          nwords = 0;
    int          quiet  = 0;
    logic [7:0]  mx     = 8'h00;
    logic [1:0]  mlh    = 2'b00;
    logic [1:0]  mb0    = 2'b00;
    logic [7:0]  mb1    = 8'h00;
    logic        e_we   = 1'b0;
    int          e_addr = 0;
    logic [17:0] e_data = '0;
    logic        e_hold = 1'b0;
    logic        e_done = 1'b0;
    logic        e_err  = 1'b0;
    logic [1:0]  e_code = 2'b00;

    // Log of writes observed on the DUT, for literal checks.
    int          nw = 0;
    logic [9:0]  la [0:1023];
    logic [17:0] ld [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_fail(input logic [1:0] c);
        e_err  = 1'b1;
        e_code = c;
        ph     = 2;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic en);
        e_we = 1'b0;
        if (ph == 0) begin
            if (v && en && d == SYNC_B) begin
                ph = 1; pos = 0; mx = 8'h00; quiet = 0;
                e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0; e_code = 2'b00;
            end
        end else if (!en) begin
            ph = 0;
        end else if (ph == 1) begin
            if (v) begin
                quiet = 0;
                if (pos == 0) begin
                    if (d[7:2] != 6'd0) model_fail(2'b01);
                    else begin mlh = d[1:0]; mx ^= d; end
                end else if (pos == 1) begin
                    nwords = int'({mlh, d}) + 1;
                    mx ^= d;
                end else if (pos < 2 + 3 * nwords) begin
                    mx ^= d;
                    case ((pos - 2) % 3)
                        0: mb0 = d[1:0];
                        1: mb1 = d;
                        default: begin
                            e_we   = 1'b1;
                            e_addr = (pos - 2) / 3;
                            e_data = {mb0, mb1, d};
                        end
                    endcase
                end else if (d == mx) begin
                    e_done = 1'b1; e_hold = 1'b0; ph = 2;
                end else begin
                    model_fail(2'b10);
                end
                pos++;
            end else if (quiet == int'(TMO) - 1) begin
                model_fail(2'b11);
            end else begin
                quiet++;
            end
        end
    endtask

    task automatic compare();
        chk("we", we, e_we);
        if (e_we) begin
            chk("waddr", waddr, e_addr);
            chk("wdata", wdata, e_data);
        end
        if (we === 1'b1 && nw < 1024) begin
            la[nw] = waddr;
            ld[nw] = wdata;
            nw++;
        end
        chk("hold", hold, e_hold);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("code", code, e_code);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        model_step(v, d, load_en);
        @(posedge clk);
        #1;
        compare();
        rx_valid = 1'b0;
    endtask

    task automatic send(input bq_t b);
        foreach (b[i]) cyc(1'b1, b[i]);
    endtask

    task automatic leave();
        load_en = 1'b0;
        cyc(1'b0, 8'h00);
        load_en = 1'b1;
        cyc(1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_hold", hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", code, 0);
        ph = 0; e_we = 1'b0; e_hold = 1'b0; e_done = 1'b0; e_err = 1'b0; e_code = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t        f;
        logic [7:0] ck;
        logic [9:0] kk;
        int         t;

        apply_reset();
        load_en = 1'b1;

        // Good 2-word frame
        f = '{8'hA5, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h24};
        nw = 0;
        send(f);
        cyc(1'b0, 8'h00);
        chk("t1_nw", nw, 2);
        chk("t1_a0", la[0], 0);
        chk("t1_d0", ld[0], 18'h3FFFF);
        chk("t1_a1", la[1], 1);
        chk("t1_d1", ld[1], 18'h01234);
        chk("t1_done", done, 1);
        chk("t1_code", code, 0);
        chk("t1_hold", hold, 0);
        leave();

        // Bad checksum
        f[9] = 8'h25;
        nw = 0;
        send(f);
        cyc(1'b0, 8'h00);
        chk("t2_nw", nw, 2);
        chk("t2_err", err, 1);
        chk("t2_code", code, 2'b10);
        chk("t2_hold", hold, 1);
        chk("t2_done", done, 0);
        leave();

        // Bytes ignored in idle, then bad length
        nw = 0;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h11);
        load_en = 1'b0;
        cyc(1'b1, 8'hA5);
        load_en = 1'b1;
        cyc(1'b0, 8'h00);
        chk("t3_idle_err_kept", err, 1);
        cyc(1'b1, 8'hA5);
        chk("t3_sync_clears", err, 0);
        cyc(1'b1, 8'h04);
        chk("t3_err", err, 1);
        chk("t3_code", code, 2'b01);
        cyc(1'b0, 8'h00);
        chk("t3_nw", nw, 0);
        leave();

        // Timeout latency
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h00);
        t = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0, 8'h00);
            if (err === 1'b1) begin
                t = i;
                break;
            end
        end
        chk("t4_latency", t, 16);
        chk("t4_code", code, 2'b11);
        leave();

        // Byte on the expiry cycle wins
        nw = 0;
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h00);
        repeat (15) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h00);
        chk("t4b_no_err", err, 0);
        send('{8'h12, 8'h34, 8'h56, 8'h70});
        cyc(1'b0, 8'h00);
        chk("t4b_done", done, 1);
        chk("t4b_d0", ld[0], 18'h23456);
        leave();

        // Full 1024-word image, bytes on consecutive cycles
        nw = 0;
        ck = 8'h03 ^ 8'hFF;
        send('{8'hA5, 8'h03, 8'hFF});
        for (int k = 0; k < 1024; k++) begin
            kk = 10'(k);
            cyc(1'b1, 8'hFC | {6'd0, kk[9:8]});
            cyc(1'b1, kk[7:0]);
            cyc(1'b1, ~kk[7:0]);
            ck = ck ^ (8'hFC | {6'd0, kk[9:8]}) ^ kk[7:0] ^ ~kk[7:0];
        end
        cyc(1'b1, ck);
        cyc(1'b0, 8'h00);
        chk("t5_nw", nw, 1024);
        chk("t5_d5", ld[5], 18'h005FA);
        chk("t5_a1023", la[1023], 10'h3FF);
        chk("t5_d1023", ld[1023], 18'h3FF00);
        chk("t5_done", done, 1);
        leave();

        // Reset while word 5 is being written
        nw = 0;
        send('{8'hA5, 8'h00, 8'h09});
        for (int k = 0; k < 5; k++) send('{8'h01, 8'(k), 8'h77});
        chk("t6_we_pre", we, 1);
        chk("t6_nw_pre", nw, 5);
        apply_reset();
        f[9] = 8'h24;
        nw = 0;
        send(f);
        cyc(1'b0, 8'h00);
        chk("t6_a0", la[0], 0);
        chk("t6_done", done, 1);
        leave();

        // LOAD_EN dropped mid-frame
        send('{8'hA5, 8'h00, 8'h01, 8'h03});
        load_en = 1'b0;
        cyc(1'b0, 8'h00);
        load_en = 1'b1;
        cyc(1'b0, 8'h00);
        chk("t7_hold", hold, 1);
        chk("t7_err", err, 0);
        chk("t7_done", done, 0);
        chk("t7_code", code, 0);
        nw = 0;
        send(f);
        cyc(1'b0, 8'h00);
        chk("t7_again_nw", nw, 2);
        chk("t7_again_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the RAT MCU: the write side of the 1024x18 program memory. It accepts a framed byte stream from the UART receiver, assembles 18-bit instructions and writes them sequentially into the program RAM write port. It holds the MCU in reset while an image is in flight and reports done or error status. It sits between the UART RX byte interface and the program memory, beside the MCU reset logic.

## Interface
- ADDR_W, 10, program memory address width (1024 words)
- DATA_W, 18, instruction width
- SYNC, 8'hA5, frame start byte
- TIMEOUT_CYC, 1_000_000, max clock cycles between bytes inside a frame

- PROG_CLK  in  1  system clock, all logic on rising edge
- PROG_RST_N  in  1  reset, asynchronous, active-low
- RX_DATA  in  8  received byte, valid only with RX_VALID
- RX_VALID  in  1  one-cycle strobe per received byte; may assert on consecutive cycles
- LOAD_EN  in  1  level; loader may start a frame only while high
- PROG_WE  out  1  program memory write enable, one cycle per word
- PROG_WADDR  out  ADDR_W  write address
- PROG_WDATA  out  DATA_W  write data
- MCU_HOLD  out  1  keep MCU in reset
- LOAD_DONE  out  1  last frame loaded and checksum good
- LOAD_ERR  out  1  last frame failed
- ERR_CODE  out  2  01 bad length, 10 checksum mismatch, 11 timeout; 00 when LOAD_ERR=0

## Operation
- Frame format: SYNC, LEN_HI, LEN_LO, then N words of 3 bytes each, then CK.
  - LEN = N-1, so N ranges 1..1024.
  - LEN_HI[1:0] = LEN[9:8]; LEN_HI[7:2] must be 0.
  - Word bytes B0,B1,B2 map to WDATA = {B0[1:0], B1, B2}; B0[7:2] is ignored.
  - CK = XOR of every byte after SYNC, excluding CK itself.
- States:
  - IDLE: on RX_VALID with LOAD_EN=1 and RX_DATA==SYNC, go to LEN_HI, set MCU_HOLD, clear LOAD_DONE/LOAD_ERR/ERR_CODE, reset address to 0 and running XOR to 0. Other bytes are ignored.
  - LEN_HI: if RX_DATA[7:2]!=0, go to ERR with code 01; otherwise go to LEN_LO.
  - LEN_LO: latch LEN[7:0], go to B0.
  - B0 -> B1 -> B2: each transition happens on one strobe.
  - At B2 strobe: register WDATA, pulse WE on the next cycle, then go to B0 if words remain, else CK. No dead state, so back-to-back strobes are never lost.
  - CK: if RX_DATA==running XOR, go to DONE; otherwise go to ERR with code 10.
  - DONE: LOAD_DONE=1, MCU_HOLD=0. Go to IDLE when LOAD_EN=0; LOAD_DONE stays 1 in IDLE until the next SYNC.
  - ERR: LOAD_ERR=1, code held. Go to IDLE when LOAD_EN=0; LOAD_ERR/ERR_CODE persist until the next SYNC.
- MCU_HOLD is sticky: it clears only on entry to DONE or on reset. A failed or aborted load leaves the MCU held.
- LOAD_EN falling in LEN_HI..CK: abort to IDLE with no error flag and MCU_HOLD kept at 1. Words already written stay written.
- Timeout: the counter clears on every RX_VALID and in IDLE/DONE/ERR. In LEN_HI..CK, a count reaching TIMEOUT_CYC-1 goes to ERR with code 11. If RX_VALID arrives on that same cycle, the byte wins.
- Address: PROG_WADDR holds the current word index and increments on the cycle after each WE. It never wraps within a frame because the length is bounded to 1024.
- Reset values: all outputs 0, state IDLE, counters 0. Memory contents are untouched by reset.

## Timing
- PROG_WE is high exactly one cycle, the cycle after the B2 strobe. PROG_WADDR and PROG_WDATA are stable in that cycle.
- Status outputs are registered and change the cycle after the deciding strobe: LOAD_DONE/LOAD_ERR/ERR_CODE and the MCU_HOLD fall.
- MCU_HOLD rises the cycle after the SYNC strobe.
- Async reset mid-frame: all outputs go to 0 immediately (including PROG_WE), with no partial write on release.
- Minimum sustainable rate: one byte per cycle.

## Test plan
- Good 2-word frame A5,00,01,03,FF,FF,00,12,34,24 -> writes 0x3FFFF at 0 and 0x01234 at 1, each WE one cycle. LOAD_DONE=1, ERR_CODE=00, MCU_HOLD 1->0.
- Same frame with CK=25 -> both writes occur, then LOAD_ERR=1, ERR_CODE=10, MCU_HOLD stays 1, LOAD_DONE=0.
- A5,04 -> ERR_CODE=01 the cycle after the 04 strobe, no WE. Bytes 00,11,A5 sent earlier in IDLE are ignored.
- TIMEOUT_CYC=16, send A5,00 then silence -> LOAD_ERR with ERR_CODE=11 exactly 16 cycles after the 00 strobe. A byte on the expiry cycle is accepted instead.
- LEN=03FF with 3072 data bytes strobed on consecutive cycles -> 1024 WE pulses at addresses 0..0x3FF in order with correct data, then correct CK gives DONE.
- Assert PROG_RST_N low during word 5 -> outputs 0 at once. A new frame after release starts at address 0. LOAD_EN dropped mid-frame -> IDLE, no error, MCU_HOLD=1.
